// File: rtl/sequence_generator_pkg.sv
// Shared definitions for the serial sequence generator and the detector benches.
package sequence_generator_pkg;

    // FSM state encodings, fixed so detector benches can decode them directly
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Default widths for pattern, length, repeat and gap fields
    localparam int DEFAULT_MAX_LEN = 8;
    localparam int DEFAULT_LEN_W   = 4;
    localparam int DEFAULT_REP_W   = 4;
    localparam int DEFAULT_GAP_W   = 4;

endpackage

// File: rtl/sequence_generator_down_counter.sv
// Loadable down counter with clock enable and zero flag; saturates at zero.
module down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value,
    output logic         zero
);

    // Load takes priority over decrement; the count never wraps below zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (en) begin
            if (load) begin
                value <= load_value;
            end else if (dec && (value != '0)) begin
                value <= value - W'(1);
            end
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated with gaps.
module sequence_generator
    import sequence_generator_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int LEN_W   = DEFAULT_LEN_W,
    parameter int REP_W   = DEFAULT_REP_W,
    parameter int GAP_W   = DEFAULT_GAP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   reps,
    input  logic [GAP_W-1:0]   gap,
    output logic               x,
    output logic               x_valid,
    output logic               busy,
    output logic               done
);

    state_t               state;
    logic [MAX_LEN-1:0]   pat_q;
    logic [LEN_W-1:0]     len_q;
    logic [GAP_W-1:0]     gap_q;

    logic [LEN_W-1:0]     len_in_eff;
    logic [MAX_LEN-1:0]   first_word;
    logic [MAX_LEN-1:0]   next_word;
    logic [MAX_LEN-1:0]   top_word;

    logic                 bit_load;
    logic                 bit_dec;
    logic [LEN_W-1:0]     bit_load_value;
    logic [LEN_W-1:0]     bit_value;
    logic                 bit_zero;

    logic                 rep_load;
    logic                 rep_dec;
    logic [REP_W-1:0]     rep_load_value;
    logic [REP_W-1:0]     rep_value;
    logic                 rep_zero;
    logic                 rep_last;

    logic                 gap_load;
    logic                 gap_dec;
    logic [GAP_W-1:0]     gap_value;
    logic                 gap_zero;
    logic                 gap_exit;

    assign rep_load_value = (reps == '0) ? REP_W'(1) : reps;

    // A cleared counter is also treated as final so a stray zero can never stall the FSM
    assign rep_last = (rep_value == REP_W'(1)) || rep_zero;
    assign gap_exit = (gap_value == GAP_W'(1)) || gap_zero;

    // Length clamp, next-bit selection and counter control derived from the current state
    always_comb begin
        len_in_eff     = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
        first_word     = pattern >> (len_in_eff - LEN_W'(1));
        next_word      = pat_q >> (bit_value - LEN_W'(1));
        top_word       = pat_q >> (len_q - LEN_W'(1));
        bit_load       = 1'b0;
        bit_dec        = 1'b0;
        bit_load_value = len_q - LEN_W'(1);
        rep_load       = 1'b0;
        rep_dec        = 1'b0;
        gap_load       = 1'b0;
        gap_dec        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    rep_load = 1'b1;
                    if (len_in_eff != '0) begin
                        bit_load       = 1'b1;
                        bit_load_value = len_in_eff - LEN_W'(1);
                    end
                end
            end
            SHIFT: begin
                if (!bit_zero) begin
                    bit_dec = 1'b1;
                end else if (!rep_last) begin
                    rep_dec = 1'b1;
                    if (gap_q != '0) begin
                        gap_load = 1'b1;
                    end else begin
                        bit_load = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_exit) begin
                    bit_load = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    down_counter #(.W(LEN_W)) bit_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (bit_load),
        .dec        (bit_dec),
        .load_value (bit_load_value),
        .value      (bit_value),
        .zero       (bit_zero)
    );

    down_counter #(.W(REP_W)) rep_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (rep_load),
        .dec        (rep_dec),
        .load_value (rep_load_value),
        .value      (rep_value),
        .zero       (rep_zero)
    );

    down_counter #(.W(GAP_W)) gap_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (gap_load),
        .dec        (gap_dec),
        .load_value (gap_q),
        .value      (gap_value),
        .zero       (gap_zero)
    );

    // State machine with registered serial outputs and shadow capture on start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pat_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    if (start) begin
                        pat_q <= pattern;
                        len_q <= len_in_eff;
                        gap_q <= gap;
                        if (len_in_eff == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state   <= SHIFT;
                            x       <= first_word[0];
                            x_valid <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (!bit_zero) begin
                        x <= next_word[0];
                    end else if (!rep_last) begin
                        if (gap_q != '0) begin
                            state   <= GAP;
                            x       <= 1'b0;
                            x_valid <= 1'b0;
                        end else begin
                            x <= top_word[0];
                        end
                    end else begin
                        state   <= FIN;
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_exit) begin
                        state   <= SHIFT;
                        x       <= top_word[0];
                        x_valid <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: cycle model plus directed traces.
module tb_sequence_generator;

    logic       clk;
    logic       rst;
    logic       en;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic [3:0] gap;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    // Expected output tuples {x, x_valid, busy, done}, one per enabled cycle
    logic [3:0] expQueue[$];
    logic [3:0] expCur;

    logic [31:0] tx, tv, tb, td;

    sequence_generator dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .reps    (reps),
        .gap     (gap),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Build the whole expected transmission from the pattern rules
    task automatic buildTransmission();
        int l;
        int r;
        l = (len > 4'd8) ? 8 : int'(len);
        r = (reps == 4'd0) ? 1 : int'(reps);
        if (l > 0) begin
            for (int k = 0; k < r; k++) begin
                for (int b = l - 1; b >= 0; b--) expQueue.push_back({pattern[b], 1'b1, 1'b1, 1'b0});
                if (k < r - 1) begin
                    for (int g = 0; g < int'(gap); g++) expQueue.push_back(4'b0010);
                end
            end
        end
        expQueue.push_back(4'b0001);
    endtask

    // Model advances on every enabled edge; a start is only accepted from idle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expQueue.delete();
            expCur = 4'b0000;
        end else if (en) begin
            if (expQueue.size() > 0) begin
                expCur = expQueue.pop_front();
            end else if (expCur[0] == 1'b0 && start) begin
                buildTransmission();
                expCur = expQueue.pop_front();
            end else begin
                expCur = 4'b0000;
            end
        end
    end

    // Compare DUT outputs against the model every cycle, away from the clock edge
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("cyc_x",       {31'd0, x},       {31'd0, expCur[3]});
            checkOutput("cyc_x_valid", {31'd0, x_valid}, {31'd0, expCur[2]});
            checkOutput("cyc_busy",    {31'd0, busy},    {31'd0, expCur[1]});
            checkOutput("cyc_done",    {31'd0, done},    {31'd0, expCur[0]});
        end
    end

    // Present parameters with a one-cycle start pulse; returns at the negedge of cycle E+1
    task automatic applyStimulus(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r, input logic [3:0] g);
        pattern = p;
        len     = l;
        reps    = r;
        gap     = g;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Record n cycles of outputs (first sample ends up in the MSB); optional en/start/pattern drive
    task automatic collect(input int n, input logic [31:0] enLow, input logic [31:0] startMask,
                           input logic [7:0] altPattern,
                           output logic [31:0] xs, output logic [31:0] xvs,
                           output logic [31:0] bs, output logic [31:0] ds);
        xs = '0; xvs = '0; bs = '0; ds = '0;
        for (int i = 0; i < n; i++) begin
            xs  = {xs[30:0], x};
            xvs = {xvs[30:0], x_valid};
            bs  = {bs[30:0], busy};
            ds  = {ds[30:0], done};
            en    = ~enLow[i];
            start = startMask[i];
            if (startMask[i]) pattern = altPattern;
            @(negedge clk);
        end
        en    = 1'b1;
        start = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        en      = 1'b1;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        gap     = '0;
        #1;
        checkOutput("reset_outputs", {28'd0, x, x_valid, busy, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single 0110, four bits then done
        applyStimulus(8'b0000_0110, 4'd4, 4'd1, 4'd0);
        collect(5, 0, 0, 8'h00, tx, tv, tb, td);
        checkOutput("t1_x",    tx, 32'b01100);
        checkOutput("t1_xv",   tv, 32'b11110);
        checkOutput("t1_busy", tb, 32'b11110);
        checkOutput("t1_done", td, 32'b00001);

        // Three repetitions with two-cycle gaps
        applyStimulus(8'b0000_0110, 4'd4, 4'd3, 4'd2);
        collect(17, 0, 0, 8'h00, tx, tv, tb, td);
        checkOutput("t2_x",    tx, 32'b0110_00_0110_00_0110_0);
        checkOutput("t2_xv",   tv, 32'b1111_00_1111_00_1111_0);
        checkOutput("t2_busy", tb, 32'b1111_11_1111_11_1111_0);
        checkOutput("t2_done", td, 32'b0000_00_0000_00_0000_1);

        // Zero length: immediate done, nothing sent
        applyStimulus(8'hFF, 4'd0, 4'd5, 4'd1);
        collect(3, 0, 0, 8'h00, tx, tv, tb, td);
        checkOutput("t3a_xv",   tv, 32'b000);
        checkOutput("t3a_busy", tb, 32'b000);
        checkOutput("t3a_done", td, 32'b100);

        // Over-long length clamps to eight bits
        applyStimulus(8'b1011_0001, 4'd12, 4'd1, 4'd0);
        collect(10, 0, 0, 8'h00, tx, tv, tb, td);
        checkOutput("t3b_x",    tx, 32'b1011_0001_00);
        checkOutput("t3b_xv",   tv, 32'b1111_1111_00);
        checkOutput("t3b_done", td, 32'b0000_0000_10);

        // Zero repeat count sends once, gap unused
        applyStimulus(8'b0000_0101, 4'd3, 4'd0, 4'd3);
        collect(5, 0, 0, 8'h00, tx, tv, tb, td);
        checkOutput("t3c_x",    tx, 32'b10100);
        checkOutput("t3c_xv",   tv, 32'b11100);
        checkOutput("t3c_done", td, 32'b00010);

        // Start presented only while disabled is never captured
        collect(4, 32'b0011, 32'b0011, 8'b0000_0110, tx, tv, tb, td);
        checkOutput("t_en_start_busy", tb, 32'b0000);

        // Enable held low for three edges after the second bit
        applyStimulus(8'b0000_0110, 4'd4, 4'd1, 4'd0);
        collect(8, 32'b0000_1110, 0, 8'h00, tx, tv, tb, td);
        checkOutput("t4_x",    tx, 32'b0111_1100);
        checkOutput("t4_xv",   tv, 32'b1111_1110);
        checkOutput("t4_busy", tb, 32'b1111_1110);
        checkOutput("t4_done", td, 32'b0000_0001);

        // Mid-transmission start ignored, start in FIN ignored, start in following idle accepted
        applyStimulus(8'b0000_0110, 4'd4, 4'd1, 4'd0);
        collect(12, 0, 32'h0000_0032, 8'b1111_1001, tx, tv, tb, td);
        checkOutput("t5_x",    tx, 32'b0110_0010_0100);
        checkOutput("t5_xv",   tv, 32'b1111_0011_1100);
        checkOutput("t5_done", td, 32'b0000_1000_0010);

        // Asynchronous reset mid-shift, then a clean restart
        applyStimulus(8'b0000_1101, 4'd4, 4'd1, 4'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_clear", {28'd0, x, x_valid, busy, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        collect(3, 0, 0, 8'h00, tx, tv, tb, td);
        checkOutput("t6_no_done", td, 32'b000);
        applyStimulus(8'b0000_1101, 4'd4, 4'd1, 4'd0);
        collect(5, 0, 0, 8'h00, tx, tv, tb, td);
        checkOutput("t6_x",    tx, 32'b11010);
        checkOutput("t6_done", td, 32'b00001);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
Serial pattern transmitter, the counterpart of the team's serial sequence detectors. It captures a programmable bit pattern, length, repeat count and inter-repeat gap on a start pulse. It then drives the pattern MSB-first, one bit per enabled clock, on a single-bit line with a valid qualifier. Its primary use is as the stimulus source feeding a detector's x input on-chip and in self-test.

Parameters:
- MAX_LEN, 8: widest pattern in bits; the pattern port is MAX_LEN wide.
- LEN_W, 4: width of the length port; must hold MAX_LEN.
- REP_W, 4: width of the repeat-count port.
- GAP_W, 4: width of the gap-length port.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- en, input, 1: clock enable. Low freezes all state and outputs.
- start, input, 1: request transmission; sampled only in IDLE with en high.
- pattern, input, MAX_LEN: bits to send; bit len-1 goes first, bit 0 last.
- len, input, LEN_W: number of pattern bits per repetition.
- reps, input, REP_W: number of repetitions; 0 is treated as 1.
- gap, input, GAP_W: idle cycles inserted between repetitions.
- x, output, 1: serial data, registered.
- x_valid, output, 1: x carries a pattern bit this cycle, registered.
- busy, output, 1: transmission in progress (SHIFT or GAP), registered.
- done, output, 1: one-cycle pulse after the final bit, registered.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, x=0, x_valid=0, busy=0, done=0, all counters and shadow registers 0. A reset mid-transmission aborts immediately with no done pulse.
- en low: no state, counter or output register changes; outputs hold their last values. A start arriving while en is low is not captured.
- States: IDLE, SHIFT, GAP, FIN.
- IDLE:
  - x=0, x_valid=0, busy=0.
  - On start=1, capture pattern, len, reps and gap into shadow registers; later input changes have no effect.
  - len > MAX_LEN is clamped to MAX_LEN.
  - len=0 goes to FIN with no bits sent.
  - Otherwise go to SHIFT.
- Latency: start sampled at edge E → first bit on x with x_valid=1 and busy=1 in the cycle after E.
- SHIFT:
  - One bit per enabled cycle, bit index decrementing from len-1 to 0.
  - After bit 0, if repetitions remain: go to GAP when gap>0, else directly to SHIFT for the next repetition's first bit. There is no dead cycle when gap=0.
  - After bit 0 of the last repetition, go to FIN.
- GAP:
  - Exactly gap enabled cycles with x=0, x_valid=0, busy=1.
  - Then return to SHIFT at bit len-1.
  - No gap follows the final repetition.
- FIN: one cycle with done=1, busy=0, x=0, x_valid=0, then IDLE. done is never asserted in any other state.
- start while busy or in FIN is ignored; no queueing.
- Total cycles from first bit to done: len*R + gap*(R-1), plus 1 for the FIN cycle, where R=max(reps,1).
- Counter widths:
  - Bit counter: LEN_W.
  - Repetition counter: REP_W, counts down to 1.
  - Gap counter: GAP_W.
  - No counter wraps; each reloads from its shadow register.

Decomposition:
- Shared package/header: state encodings (IDLE=0, SHIFT=1, GAP=2, FIN=3) and default widths, shared with the detector testbenches.
- One natural sub-module: down_counter, with load, enable, value and zero flag. It is instantiated three times (bit, repetition, gap). The FSM and output registers stay in sequence_generator.

Test Plan:
1. pattern=8'b0000_0110, len=4, reps=1, gap=0, start at edge E:
   - x=0,1,1,0 with x_valid=1 in cycles E+1..E+4.
   - done=1 in cycle E+5.
   - Feeding x to the 0110 detector gives z=1 during the final 0.
2. Same pattern, reps=3, gap=2:
   - x_valid pattern 1111 00 1111 00 1111; x=0 during the gaps.
   - busy high for 16 cycles; done in cycle E+17.
3. Boundary values:
   - len=0, reps=5 → x_valid never asserts; done in cycle E+1.
   - len=12 with MAX_LEN=8 → 8 bits sent, pattern[7] first.
   - reps=0 → sent once.
4. Hold en low for 3 cycles after the second bit → x, x_valid and busy frozen. Transmission resumes with the third bit; done is delayed by exactly 3 cycles.
5. Inputs during and after a transmission:
   - start pulse and changed pattern mid-transmission → ignored; the original bits complete.
   - start asserted in the FIN cycle → ignored.
   - start one cycle later (IDLE) → accepted.
6. Assert rst asynchronously mid-SHIFT → outputs go to 0 without waiting for a clock edge, and no done pulse. A start after reset release begins cleanly at bit len-1.
